// File: rtl/sort_sched_pkg.sv
// Shared types and width helpers for the sort frame scheduler.
// Flits are packed {rx, tx, data}; pads carry all-ones rx/tx so they sort last.
package sort_sched_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_COLLECT = 3'd1,
        ST_LAUNCH  = 3'd2,
        ST_SORT    = 3'd3,
        ST_HOLD    = 3'd4
    } state_t;

    // Upper bound on flit width for the pad builder; FW must not exceed it.
    localparam int PAD_MAX_W = 4096;

    function automatic int pw_of(input int port_nub);
        return $clog2(port_nub);
    endfunction

    function automatic int fw_of(input int port_nub, input int data_width);
        return 2 * $clog2(port_nub) + data_width;
    endfunction

    function automatic logic [PAD_MAX_W-1:0] pad_flit(input int pw, input int data_width);
        logic [PAD_MAX_W-1:0] ones;
        ones = '1;
        return (~(ones << (2 * pw))) << data_width;
    endfunction

endpackage

// File: rtl/popcount_n.sv
// Counts set bits of an N-bit vector; used for the real-flit count of a frame.
module popcount_n #(
    parameter int N = 16,
    parameter int W = $clog2(N) + 1
) (
    input  logic [N-1:0] bits,
    output logic [W-1:0] count
);

    always_comb begin
        count = '0;
        for (int i = 0; i < N; i++) begin
            count = count + W'(bits[i]);
        end
    end

endmodule

// File: rtl/sort_frame_scheduler.sv
// Gathers one flit per port into a frame, launches it into an external sorting
// network, and holds the sorted result until the consumer takes it.
//
// state   | meaning
// IDLE    | no slot occupied, window closed
// COLLECT | window open, slots filling, window counter running
// LAUNCH  | one cycle: frame (with pads) registered into the network
// SORT    | waiting SORT_LATENCY cycles for the network result
// HOLD    | sorted frame presented until out_ready
module sort_frame_scheduler
    import sort_sched_pkg::*;
#(
    parameter int  DATA_WIDTH     = 128,
    parameter int  PORT_NUB       = 16,
    parameter int  SORT_LATENCY   = 10,
    parameter int  COLLECT_CYCLES = 4,
    localparam int PW             = pw_of(PORT_NUB),
    localparam int FW             = fw_of(PORT_NUB, DATA_WIDTH)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [PORT_NUB-1:0]    in_valid,
    output logic [PORT_NUB-1:0]    in_ready,
    input  logic [PORT_NUB*FW-1:0] in_flit,
    output logic [PORT_NUB*FW-1:0] net_in,
    output logic                   net_launch,
    input  logic [PORT_NUB*FW-1:0] net_out,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [PORT_NUB*FW-1:0] out_flit,
    output logic [PW:0]            out_count,
    output logic [15:0]            drop_cnt
);

    localparam int CW = $clog2(COLLECT_CYCLES + 1);
    localparam int LW = $clog2(SORT_LATENCY + 1);
    localparam logic [CW-1:0] WIN_LAST = CW'(COLLECT_CYCLES - 1);
    localparam logic [LW-1:0] LAT_LAST = LW'(SORT_LATENCY - 1);
    localparam logic [FW-1:0] PAD_FLIT = FW'(pad_flit(PW, DATA_WIDTH));

    state_t              state, state_nx;
    logic [PORT_NUB-1:0] slot_full;
    logic [FW-1:0]       slot_q [PORT_NUB];
    logic [CW-1:0]       win_cnt;
    logic [LW-1:0]       lat_cnt;
    logic [PW:0]         frame_count;
    logic [PW:0]         drop_num;
    logic [16:0]         drop_sum;
    logic [PORT_NUB-1:0] take, drop, fill;
    logic                capture, release_frame;

    popcount_n #(
        .N (PORT_NUB),
        .W (PW + 1)
    ) u_popcount (
        .bits  (slot_full),
        .count (frame_count)
    );

    always_comb begin
        in_ready = '0;
        take     = '0;
        drop     = '0;
        drop_num = '0;
        for (int i = 0; i < PORT_NUB; i++) begin
            in_ready[i] = !rst && !slot_full[i] && (state != ST_LAUNCH);
            take[i]     = in_valid[i] && in_ready[i];
            // A flit addressed to its own source is never admitted, which keeps
            // rx == tx == all-ones unambiguous as the pad marker.
            drop[i]     = take[i] && (in_flit[i*FW + DATA_WIDTH + PW +: PW] ==
                                      in_flit[i*FW + DATA_WIDTH +: PW]);
            drop_num    = drop_num + (PW + 1)'(drop[i]);
        end
        fill     = take & ~drop;
        drop_sum = {1'b0, drop_cnt} + 17'(drop_num);
    end

    always_comb begin
        state_nx      = state;
        capture       = 1'b0;
        release_frame = 1'b0;
        case (state)
            ST_IDLE: begin
                if (|slot_full) state_nx = ST_COLLECT;
            end
            ST_COLLECT: begin
                if ((&slot_full) || (win_cnt == WIN_LAST)) state_nx = ST_LAUNCH;
            end
            ST_LAUNCH: begin
                state_nx = ST_SORT;
            end
            ST_SORT: begin
                if (lat_cnt == LAT_LAST) begin
                    capture  = 1'b1;
                    state_nx = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (out_ready) begin
                    release_frame = 1'b1;
                    state_nx      = (|slot_full) ? ST_COLLECT : ST_IDLE;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nx;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            slot_full  <= '0;
            net_in     <= '0;
            net_launch <= 1'b0;
            out_valid  <= 1'b0;
            out_flit   <= '0;
            out_count  <= '0;
            drop_cnt   <= '0;
            win_cnt    <= '0;
            lat_cnt    <= '0;
        end else begin
            win_cnt    <= (state == ST_COLLECT) ? win_cnt + CW'(1) : '0;
            lat_cnt    <= (state == ST_SORT) ? lat_cnt + LW'(1) : '0;
            net_launch <= (state == ST_LAUNCH);
            drop_cnt   <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
            if (state == ST_LAUNCH) begin
                slot_full <= '0;
                out_count <= frame_count;
                for (int i = 0; i < PORT_NUB; i++) begin
                    net_in[i*FW +: FW] <= slot_full[i] ? slot_q[i] : PAD_FLIT;
                end
            end else begin
                slot_full <= slot_full | fill;
            end
            if (capture) begin
                out_flit  <= net_out;
                out_valid <= 1'b1;
            end else if (release_frame) begin
                out_valid <= 1'b0;
            end
        end
    end

    // Payload storage needs no reset; slot_full qualifies every use.
    always_ff @(posedge clk) begin
        for (int i = 0; i < PORT_NUB; i++) begin
            if (fill[i]) slot_q[i] <= in_flit[i*FW +: FW];
        end
    end

endmodule

// File: doc/sort_frame_scheduler.md
SORT_FRAME_SCHEDULER -- requirements
Module: sort_frame_scheduler

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 128: payload bits per flit.
REQ-002 SHALL have parameter PORT_NUB, default 16: number of ports, a power of two >= 2; PW = $clog2(PORT_NUB); flit width FW = 2*PW + DATA_WIDTH, packed {rx, tx, data}.
REQ-003 SHALL have parameter SORT_LATENCY, default 10: register stages of the attached sorting network.
REQ-004 SHALL have parameter COLLECT_CYCLES, default 4: collection window length in cycles, >= 1.
REQ-005 clk  in  1  sole clock; all logic on rising edge.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 in_valid  in  PORT_NUB  per-port flit offer.
REQ-008 in_ready  out  PORT_NUB  per-port accept; a flit transfers when in_valid[i] && in_ready[i].
REQ-009 in_flit  in  PORT_NUB*FW  port i occupies bits [i*FW +: FW].
REQ-010 net_in  out  PORT_NUB*FW  registered frame driven into the sorting network.
REQ-011 net_launch  out  1  one-cycle pulse, coincident with the net_in update.
REQ-012 net_out  in  PORT_NUB*FW  sorting network output.
REQ-013 out_valid  out  1  sorted frame available.
REQ-014 out_ready  in  1  consumer accepts the frame.
REQ-015 out_flit  out  PORT_NUB*FW  captured sorted frame, ascending rx.
REQ-016 out_count  out  PW+1  number of real flits in the frame.
REQ-017 drop_cnt  out  16  count of rejected flits, saturating at 16'hFFFF.

Function
REQ-018 SHALL hold one slot register per port with a full flag; in_ready[i] = !slot_full[i] && state != LAUNCH.
REQ-019 SHALL, on an accepted flit with rx == tx, consume it without filling the slot and increment drop_cnt.
REQ-020 SHALL implement FSM IDLE, COLLECT, LAUNCH, SORT, HOLD.
REQ-021 IDLE -> COLLECT when any slot_full is set; the window counter clears on entry.
REQ-022 COLLECT -> LAUNCH when all slots are full or the window counter reaches COLLECT_CYCLES-1, whichever comes first.
REQ-023 LAUNCH (one cycle): net_in <= slot contents, with empty slots replaced by the pad flit {rx=all-ones, tx=all-ones, data=0}; net_launch=1; out_count <= popcount(slot_full); all slots clear; next state SORT.
REQ-024 SORT SHALL last exactly SORT_LATENCY cycles. net_out is captured into out_flit on the edge SORT_LATENCY cycles after the net_in update; out_valid=1 from that edge; next state HOLD.
REQ-025 HOLD: out_flit and out_count are stable while out_valid && !out_ready.
REQ-026 On out_ready, out_valid clears next cycle. The FSM goes to COLLECT if any slot is full, otherwise IDLE.
REQ-027 SHALL accept flits into empty slots during SORT and HOLD; the window counter does not run until COLLECT.
REQ-028 A simultaneous last-slot fill and window expiry SHALL produce a single LAUNCH.
REQ-029 SHALL keep at most one frame in flight; no LAUNCH while in SORT or HOLD.
REQ-030 Pads SHALL sort last. Because rx == tx flits are never admitted, consumers identify pads by rx == tx == all-ones.

Reset
REQ-031 While rst=1: state=IDLE; all slot_full flags, net_in, net_launch, out_valid, out_flit, out_count, drop_cnt and window/latency counters=0; in_ready=0.
REQ-032 Reset asserted mid-frame SHALL discard the in-flight frame and all slots; the first in_ready=1 is the cycle after rst deasserts.

Structure
REQ-033 Package sort_sched_pkg SHALL hold the FSM state enumeration, the FW/PW width helpers and the pad-flit constant.
REQ-034 A popcount sub-module, popcount_n, SHALL compute out_count; everything else stays flat in one module.

Verification (PORT_NUB=4, SORT_LATENCY=3, COLLECT_CYCLES=4; network modelled as a sorter with 3-cycle delay)
REQ-035 Ports 0..3 offer rx=3,1,2,0 (tx≠rx) in the same cycle -> LAUNCH next cycle; out_valid 3 cycles after net_launch; out_flit rx order 0,1,2,3; out_count=4.
REQ-036 Only port 2 offers rx=1, tx=2 -> LAUNCH after a 4-cycle window; out_flit[0] is the real flit; slots 1..3 are pads; out_count=1.
REQ-037 Port 1 offers rx=1, tx=1 -> accepted, drop_cnt 0->1, FSM stays IDLE.
REQ-038 out_ready held 0 for 5 cycles while new flits arrive -> out_flit stable; no second net_launch until the cycle after out_ready=1; the next frame then launches.
REQ-039 rst pulsed during SORT -> out_valid never rises; all outputs 0; a fresh frame afterwards sorts correctly.
